// File: rtl/ifetch_prefetch_queue.sv
// Instruction-fetch prefetch queue: credit-limited in-order imem fetches, {pc,instr} buffer, redirect flush.
// Optional IFQ_BYPASS_EN: a response that arrives while the queue is empty drives the outputs in the same cycle.
module ifetch_prefetch_queue #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned MAX_OUTSTD = 2,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic                     imem_req_valid,
   input  logic                     imem_req_ready,
   output logic [31:0]              imem_req_addr,
   input  logic                     imem_rsp_valid,
   input  logic [31:0]              imem_rsp_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_instr,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned OW = $clog2(DEPTH) + 1;
   localparam int unsigned FW = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;
   localparam int unsigned CW = $clog2(MAX_OUTSTD + 1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   q_pc_q    [DEPTH];
   logic [31:0]   q_instr_q [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [OW-1:0] occ_q, occ_d;
   logic [31:0]   fl_pc_q [MAX_OUTSTD];
   logic [FW-1:0] fl_rd_q, fl_rd_d, fl_wr_q, fl_wr_d;
   logic [CW-1:0] outstd_q, outstd_d, drop_q, drop_d;

   logic req_fire, rsp_ok, rsp_keep, bypass, push, pop;

   function automatic logic [FW-1:0] fl_inc(input logic [FW-1:0] p);
      return (32'(p) == MAX_OUTSTD - 1) ? '0 : p + FW'(1);
   endfunction

   always_comb begin
      imem_req_valid = !rst && !redirect_valid && (32'(outstd_q) < MAX_OUTSTD)
                       && ((32'(outstd_q) + 32'(occ_q)) < DEPTH);
      imem_req_addr  = fetch_pc_q;
      req_fire       = imem_req_valid && imem_req_ready;
      rsp_ok         = imem_rsp_valid && (outstd_q != '0);
      rsp_keep       = rsp_ok && (drop_q == '0) && !redirect_valid;
`ifdef IFQ_BYPASS_EN
      bypass         = !rst && rsp_keep && (occ_q == '0);
`else
      bypass         = 1'b0;
`endif
      out_valid      = (occ_q != '0) || bypass;
      out_pc         = bypass ? fl_pc_q[fl_rd_q] : q_pc_q[head_q];
      out_instr      = bypass ? imem_rsp_data    : q_instr_q[head_q];
      occupancy      = occ_q;
      pop            = (occ_q != '0) && out_ready && !redirect_valid;
      push           = rsp_keep && !(bypass && out_ready);
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      head_d     = head_q;
      tail_d     = tail_q;
      occ_d      = occ_q;
      fl_rd_d    = fl_rd_q;
      fl_wr_d    = fl_wr_q;
      outstd_d   = outstd_q;
      drop_d     = drop_q;

      if (req_fire) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         fl_wr_d    = fl_inc(fl_wr_q);
      end
      if (rsp_ok) fl_rd_d = fl_inc(fl_rd_q);
      if (req_fire && !rsp_ok)      outstd_d = outstd_q + CW'(1);
      else if (!req_fire && rsp_ok) outstd_d = outstd_q - CW'(1);

      if (redirect_valid) begin
         // Every request still in flight after this edge is stale, including ones already marked.
         fetch_pc_d = redirect_pc;
         occ_d      = '0;
         tail_d     = head_q;
         drop_d     = outstd_q - CW'(rsp_ok);
      end else begin
         if (rsp_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);
         if (pop)  head_d = head_q + AW'(1);
         if (push) tail_d = tail_q + AW'(1);
         if (push && !pop)      occ_d = occ_q + OW'(1);
         else if (!push && pop) occ_d = occ_q - OW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         occ_q      <= '0;
         fl_rd_q    <= '0;
         fl_wr_q    <= '0;
         outstd_q   <= '0;
         drop_q     <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_pc_q[i]    <= '0;
            q_instr_q[i] <= '0;
         end
         for (int unsigned i = 0; i < MAX_OUTSTD; i++) fl_pc_q[i] <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         occ_q      <= occ_d;
         fl_rd_q    <= fl_rd_d;
         fl_wr_q    <= fl_wr_d;
         outstd_q   <= outstd_d;
         drop_q     <= drop_d;
         if (push) begin
            q_pc_q[tail_q]    <= fl_pc_q[fl_rd_q];
            q_instr_q[tail_q] <= imem_rsp_data;
         end
         if (req_fire) fl_pc_q[fl_wr_q] <= fetch_pc_q;
      end
   end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Bench for ifetch_prefetch_queue: queue-based reference model checked every cycle, plus literal pins.
// Build with IFQ_BYPASS_EN defined to exercise the zero-latency response path.
module tb_ifetch_prefetch_queue;

   localparam int unsigned DEPTH      = 4;
   localparam int unsigned MAX_OUTSTD = 2;
   localparam logic [31:0] RESET_PC   = 32'h0;
`ifdef IFQ_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic        clk, rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = '0;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_instr;
   logic [$clog2(DEPTH):0] occupancy;

   ifetch_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTD(MAX_OUTSTD), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .occupancy(occupancy)
   );

   typedef struct { logic [31:0] pc; bit drop; } fl_t;

   int          n_cmp = 0, n_bad = 0;
   fl_t         m_fl[$];
   logic [31:0] m_qpc[$], m_qin[$];
   logic [31:0] m_pc;
   logic [31:0] pend[$], seen_pop[$], seen_ins[$], seen_req[$];
   bit          rsp_en;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] img(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // imem: answers each accepted request exactly one cycle later while rsp_en is set
   always begin
      @(posedge clk);
      #1;
      if (rst) begin
         pend.delete();
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end else if (rsp_en && pend.size() > 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = img(pend.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_occupancy", 32'(occupancy), 32'd0);
         chk("rst_out_pc", out_pc, 32'd0);
         chk("rst_out_instr", out_instr, 32'd0);
         m_fl.delete(); m_qpc.delete(); m_qin.delete();
         m_pc = RESET_PC;
      end else begin
         logic rsp, byp, ev, erv, pop;
         logic [31:0] epc, ein;
         fl_t e;
         rsp = imem_rsp_valid && (m_fl.size() > 0);
         byp = BYP && (m_qpc.size() == 0) && rsp && !m_fl[0].drop && !redirect_valid;
         ev  = (m_qpc.size() > 0) || byp;
         epc = (m_qpc.size() > 0) ? m_qpc[0] : (byp ? m_fl[0].pc : 32'd0);
         ein = (m_qpc.size() > 0) ? m_qin[0] : imem_rsp_data;
         erv = !redirect_valid && (m_fl.size() < int'(MAX_OUTSTD))
               && (m_fl.size() + m_qpc.size() < int'(DEPTH));

         chk("out_valid", 32'(out_valid), 32'(ev));
         chk("occupancy", 32'(occupancy), 32'(m_qpc.size()));
         if (ev) begin
            chk("out_pc", out_pc, epc);
            chk("out_instr", out_instr, ein);
         end
         chk("req_valid", 32'(imem_req_valid), 32'(erv));
         if (erv) chk("req_addr", imem_req_addr, m_pc);

         if (out_valid && out_ready && !redirect_valid) begin
            seen_pop.push_back(out_pc);
            seen_ins.push_back(out_instr);
         end
         if (imem_req_valid && imem_req_ready) begin
            seen_req.push_back(imem_req_addr);
            pend.push_back(imem_req_addr);
         end

         pop = (m_qpc.size() > 0) && out_ready && !redirect_valid;
         if (pop) begin
            void'(m_qpc.pop_front());
            void'(m_qin.pop_front());
         end
         if (rsp) begin
            e = m_fl.pop_front();
            if (!e.drop && !redirect_valid && !(byp && out_ready)) begin
               m_qpc.push_back(e.pc);
               m_qin.push_back(imem_rsp_data);
            end
         end
         if (redirect_valid) begin
            m_qpc.delete(); m_qin.delete();
            for (int i = 0; i < m_fl.size(); i++) begin
               fl_t t;
               t = m_fl[i];
               t.drop = 1'b1;
               m_fl[i] = t;
            end
            m_pc = redirect_pc;
         end else if (erv && imem_req_ready) begin
            m_fl.push_back('{pc: m_pc, drop: 1'b0});
            m_pc = m_pc + 32'd4;
         end
      end
   end

   initial begin
      int found;
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      out_ready = 1'b1; imem_req_ready = 1'b1; rsp_en = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // streaming from reset; first response checks the latency mode
      tick();
      #1;
      chk("first_rsp_out_valid", 32'(out_valid), 32'(BYP));
      chk("first_rsp_occupancy", 32'(occupancy), 32'd0);
      repeat (6) tick();
      imem_req_ready = 1'b0;
      repeat (3) tick();
      imem_req_ready = 1'b1;
      repeat (8) tick();
      chk("stream_pop0", at(seen_pop, 0), 32'h0);
      chk("stream_pop1", at(seen_pop, 1), 32'h4);
      chk("stream_pop2", at(seen_pop, 2), 32'h8);
      chk("stream_ins1", at(seen_ins, 1), 32'hC0DE_0004);
      chk("stream_req2", at(seen_req, 2), 32'h8);

      // decode stall from reset: queue saturates, head held
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      out_ready = 1'b0;
      repeat (20) tick();
      #1;
      chk("stall_occupancy", 32'(occupancy), 32'd4);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_pc", out_pc, 32'h0);
      chk("stall_out_instr", out_instr, 32'hC0DE_0000);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);

      // drain with imem silent until two requests are in flight, then redirect
      out_ready = 1'b1;
      rsp_en = 1'b0;
      repeat (4) tick();
      chk("pre_redir_occupancy", 32'(occupancy), 32'd0);
      seen_pop.delete(); seen_ins.delete();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      rsp_en = 1'b1;
      repeat (10) tick();
      chk("redir_pop0", at(seen_pop, 0), 32'h100);
      chk("redir_pop1", at(seen_pop, 1), 32'h104);
      chk("redir_ins0", at(seen_ins, 0), 32'hC0DE_0100);

      // redirect coinciding with a response and a pop attempt
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         tick();
         out_ready = 1'b0;
         #1;
         if (imem_rsp_valid && out_valid) found = 1;
      end
      chk("coincide_setup", 32'(found), 32'd1);
      seen_pop.delete(); seen_ins.delete();
      out_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      repeat (10) tick();
      chk("coincide_pop0", at(seen_pop, 0), 32'h200);
      chk("coincide_pop1", at(seen_pop, 1), 32'h204);

      // fetch address wraps through zero
      seen_req.delete(); seen_pop.delete();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      repeat (8) tick();
      chk("wrap_req0", at(seen_req, 0), 32'hFFFF_FFFC);
      chk("wrap_req1", at(seen_req, 1), 32'h0);
      chk("wrap_pop1", at(seen_pop, 1), 32'h0);

      // reset in the middle of traffic
      rst = 1'b1;
      seen_req.delete(); seen_pop.delete();
      repeat (2) tick();
      rst = 1'b0;
      repeat (8) tick();
      chk("rerst_req0", at(seen_req, 0), RESET_PC);
      chk("rerst_pop0", at(seen_pop, 0), RESET_PC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
